lbist_pattern_seq: RTL and testbench
====================================

Name: lbist_pattern_seq

Overview:
- Sequences the deterministic test-pattern memory (flash, read-only use) for LBIST.
- On a start pulse it fetches num_pat consecutive words starting at base_add, one read at a time.
- It registers each word and presents it to the downstream scan/CUT loader on a valid/ready handshake.
- It sits between the LBIST top-level controller and the pattern memory instance, and is the only master of that memory's control pins.

Parameters:
- word_size, 8, pattern word width; must equal the memory's word_size.
- address_bits, 8, memory address width; must equal the memory's address_bits.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin a sequence; sampled only in IDLE.
- abort  input  1  terminate the current sequence; highest priority after rst.
- base_add  input  address_bits  first pattern address; sampled on accepted start.
- num_pat  input  address_bits+1  pattern count (0..2^address_bits); sampled on accepted start.
- mem_en  output  1  memory chip enable.
- mem_rw  output  1  memory read/write; constant 0 (read).
- mem_add  output  address_bits  memory address.
- mem_data  input  word_size  memory data net; read side of the memory's inout.
- pat_data  output  word_size  registered pattern word.
- pat_valid  output  1  pat_data holds an unconsumed pattern.
- pat_ready  input  1  downstream accepts pat_data when pat_valid && pat_ready at a posedge.
- pat_idx  output  address_bits+1  index of the pattern on pat_data (0-based).
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse on normal completion.

Behaviour:
- Reset (asynchronous): state=IDLE. Outputs mem_en, pat_valid, busy and done are 0. Registers pat_data, mem_add and pat_idx are 0. mem_rw is always 0.
- States and transitions:
  - IDLE -> FETCH on start. Latch base_add and num_pat; clear the index counter.
  - IDLE -> DONE on start with num_pat==0. No memory access occurs.
  - FETCH (1 cycle): mem_en=1, mem_add=(base_add+idx) mod 2^address_bits. Memory registers the word at this posedge. Next state is CAPT.
  - CAPT (1 cycle): mem_en=0; mem_data is valid and is held by the memory. At the posedge: pat_data<=mem_data, pat_idx<=idx, pat_valid<=1. Next state is PRESENT.
  - PRESENT: hold pat_data and pat_valid until handshake. On handshake, pat_valid<=0 and idx<=idx+1. If idx+1==num_pat, go to DONE; else go to FETCH.
  - DONE (1 cycle): done=1, busy=1. Next state is IDLE.
- Latency and throughput:
  - start to first pat_valid is 3 cycles (IDLE, FETCH, CAPT).
  - Sustained throughput is one pattern per 3 cycles with pat_ready held high.
- mem_en is asserted only in FETCH, for exactly one cycle per pattern. Total mem_en cycles per pass equals num_pat.
- Address wrap: addition is modulo 2^address_bits. Example: base_add=0xFE with num_pat=4 reads 0xFE, 0xFF, 0x00, 0x01.
- num_pat==2^address_bits reads every location exactly once.
- start while busy is ignored, and the latched base_add/num_pat are unaffected.
- abort in any non-IDLE state: next state is IDLE. pat_valid<=0 and mem_en<=0, with no done pulse. abort in IDLE has no effect.
- abort and start in the same IDLE cycle: abort wins and the sequence is not started.
- rst asserted mid-sequence returns all state and outputs to reset values immediately. No done pulse follows.
- pat_ready while pat_valid=0 is ignored.
- pat_data and pat_idx are stable while pat_valid=1 and no handshake has occurred.

Optional Feature:
- Macro: LBIST_SEQ_LOOP_EN.
- Defined:
  - Adds port loop_cnt (input, 8 bits), sampled on accepted start.
  - The full base_add..num_pat sequence repeats loop_cnt+1 times.
  - After the last pattern of a non-final pass, the next state is FETCH with idx=0.
  - pat_idx restarts at 0 each pass.
  - done pulses once, after the final pass only.
  - abort exits at any pass.
- Undefined: no loop_cnt port; a single pass.

Decomposition:
- Shared package lbist_pkg:
  - State encoding enum: IDLE, FETCH, CAPT, PRESENT, DONE.
  - Constant MEM_READ=1'b0 for mem_rw.
- One natural sub-module: lbist_addr_gen, the base+index counter with modulo wrap and terminal-count flag.
- The FSM and output register stay in the top module.

Test Plan:
- Basic pass: memory holds 0x11,0x22,0x33 at 0x00..0x02; start, base_add=0, num_pat=3, pat_ready=1.
  - Required: pat_data 0x11,0x22,0x33 with pat_idx 0,1,2.
  - First pat_valid 3 cycles after start; done 1 cycle after the third handshake; exactly 3 mem_en cycles.
- Backpressure: pat_ready=0 for 10 cycles on pattern 1.
  - Required: pat_data=0x22 and pat_valid=1 held; no mem_en during the stall; stream resumes in order.
- Wrap and zero count:
  - base_add=0xFE, num_pat=4: mem_add sequence 0xFE, 0xFF, 0x00, 0x01.
  - num_pat=0: done one cycle after start, no mem_en, pat_valid never high.
- Abort and ignored start:
  - abort during the PRESENT of pattern 1: IDLE next cycle, pat_valid=0, no done.
  - start pulsed mid-sequence: no effect on address or count.
- Async reset mid-FETCH: rst asserted between clock edges.
  - Required: mem_en, pat_valid and busy drop to 0 without waiting for a clock edge.
  - After release, a new start runs normally.
- LBIST_SEQ_LOOP_EN: loop_cnt=2, num_pat=2.
  - Required: 6 handshakes with pat_idx 0,1,0,1,0,1 and a single done.

Source files
------------

// File: rtl/lbist_pkg.sv
// Shared types and constants for the LBIST pattern sequencer.
package lbist_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    CAPT,
    PRESENT,
    DONE
  } state_t;

  localparam logic MEM_READ = 1'b0;

endpackage

// File: rtl/lbist_pattern_seq_if.sv
// Pattern-memory control pins plus the downstream pattern valid/ready stream.
interface lbist_pattern_seq_if #(
  parameter int word_size    = 8,
  parameter int address_bits = 8
);
  logic                    mem_en;
  logic                    mem_rw;
  logic [address_bits-1:0] mem_add;
  logic [word_size-1:0]    mem_data;
  logic [word_size-1:0]    pat_data;
  logic                    pat_valid;
  logic                    pat_ready;
  logic [address_bits:0]   pat_idx;

  modport master (
    output mem_en, mem_rw, mem_add, pat_data, pat_valid, pat_idx,
    input  mem_data, pat_ready
  );

  modport slave (
    input  mem_en, mem_rw, mem_add, pat_data, pat_valid, pat_idx,
    output mem_data, pat_ready
  );
endinterface

// File: rtl/lbist_addr_gen.sv
// Base + index address counter with modulo-2^address_bits wrap and terminal-count flag.
module lbist_addr_gen #(
  parameter int address_bits = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic                    clr,
  input  logic                    step,
  input  logic [address_bits-1:0] base_add,
  input  logic [address_bits:0]   num_pat,
  output logic [address_bits-1:0] addr,
  output logic [address_bits:0]   idx,
  output logic                    last
);
  localparam logic [address_bits:0] ONE = {{address_bits{1'b0}}, 1'b1};

  logic [address_bits-1:0] base_reg;
  logic [address_bits:0]   num_reg;
  logic [address_bits:0]   idx_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_reg <= '0;
      num_reg  <= '0;
      idx_reg  <= '0;
    end else if (load) begin
      base_reg <= base_add;
      num_reg  <= num_pat;
      idx_reg  <= '0;
    end else if (clr) begin
      idx_reg <= '0;
    end else if (step) begin
      idx_reg <= idx_reg + ONE;
    end
  end

  // Dropping the index MSB makes the sum wrap naturally at the top of memory.
  assign addr = base_reg + idx_reg[address_bits-1:0];
  assign idx  = idx_reg;
  assign last = ((idx_reg + ONE) == num_reg);
endmodule

// File: rtl/lbist_pattern_seq.sv
// LBIST pattern-memory sequencer: fetch, register and hand off num_pat words.
// Optional multi-pass repetition is enabled with `define LBIST_SEQ_LOOP_EN.
module lbist_pattern_seq
  import lbist_pkg::*;
#(
  parameter int word_size    = 8,
  parameter int address_bits = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic [address_bits-1:0] base_add,
  input  logic [address_bits:0]   num_pat,
`ifdef LBIST_SEQ_LOOP_EN
  input  logic [7:0]              loop_cnt,
`endif
  output logic                    busy,
  output logic                    done,
  lbist_pattern_seq_if.master     bus
);
  state_t state_reg, state_next;

  logic                    load, step, restart, handshake, last, more_passes;
  logic [address_bits-1:0] addr;
  logic [address_bits:0]   idx;
  logic [word_size-1:0]    pat_data_reg;
  logic [address_bits:0]   pat_idx_reg;
  logic                    pat_valid_reg;

  lbist_addr_gen #(.address_bits(address_bits)) u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .clr      (restart),
    .step     (step),
    .base_add (base_add),
    .num_pat  (num_pat),
    .addr     (addr),
    .idx      (idx),
    .last     (last)
  );

`ifdef LBIST_SEQ_LOOP_EN
  logic [7:0] loop_reg, pass_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      loop_reg <= '0;
      pass_reg <= '0;
    end else if (load) begin
      loop_reg <= loop_cnt;
      pass_reg <= '0;
    end else if (restart) begin
      pass_reg <= pass_reg + 8'd1;
    end
  end

  assign more_passes = (pass_reg != loop_reg);
`else
  assign more_passes = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    step       = 1'b0;
    restart    = 1'b0;
    handshake  = pat_valid_reg && bus.pat_ready;
    case (state_reg)
      IDLE: begin
        if (start && !abort) begin
          load       = 1'b1;
          state_next = (num_pat == '0) ? DONE : FETCH;
        end
      end
      FETCH:   state_next = CAPT;
      CAPT:    state_next = PRESENT;
      PRESENT: begin
        if (handshake) begin
          if (last && more_passes) begin
            restart    = 1'b1;
            state_next = FETCH;
          end else begin
            step       = 1'b1;
            state_next = last ? DONE : FETCH;
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    // Abort overrides everything outside IDLE and suppresses the done pulse.
    if (abort && state_reg != IDLE) begin
      state_next = IDLE;
      load       = 1'b0;
      step       = 1'b0;
      restart    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat_data_reg  <= '0;
      pat_idx_reg   <= '0;
      pat_valid_reg <= 1'b0;
    end else if (abort && state_reg != IDLE) begin
      pat_valid_reg <= 1'b0;
    end else if (state_reg == CAPT) begin
      pat_data_reg  <= bus.mem_data;
      pat_idx_reg   <= idx;
      pat_valid_reg <= 1'b1;
    end else if (handshake) begin
      pat_valid_reg <= 1'b0;
    end
  end

  // Control outputs decode straight from state so async reset clears them at once.
  assign bus.mem_en    = (state_reg == FETCH);
  assign bus.mem_rw    = MEM_READ;
  assign bus.mem_add   = addr;
  assign bus.pat_data  = pat_data_reg;
  assign bus.pat_idx   = pat_idx_reg;
  assign bus.pat_valid = pat_valid_reg;
  assign busy          = (state_reg != IDLE);
  assign done          = (state_reg == DONE);
endmodule

// File: tb/tb_lbist_pattern_seq.sv
// Self-checking bench for lbist_pattern_seq: vector table, corner sequences, random runs.
module tb_lbist_pattern_seq;
  import lbist_pkg::*;

  localparam int WS = 8;
  localparam int AB = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AB-1:0] base_add = '0;
  logic [AB:0]   num_pat = '0;
  logic          busy, done;
`ifdef LBIST_SEQ_LOOP_EN
  logic [7:0]    loop_cnt = '0;
`endif

  lbist_pattern_seq_if #(.word_size(WS), .address_bits(AB)) bus ();

  lbist_pattern_seq #(.word_size(WS), .address_bits(AB)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .base_add (base_add),
    .num_pat  (num_pat),
`ifdef LBIST_SEQ_LOOP_EN
    .loop_cnt (loop_cnt),
`endif
    .busy     (busy),
    .done     (done),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  // Read-only memory model: word registered on the enabled edge, then held.
  logic [WS-1:0] mem [256];
  logic [WS-1:0] mem_q;
  always @(posedge clk) if (bus.mem_en) mem_q <= mem[bus.mem_add];
  assign bus.mem_data = mem_q;

  typedef struct {
    logic [7:0]  d;
    logic [8:0]  idx;
  } hs_t;

  typedef struct {
    logic [7:0] base;
    int         num;
    int         rdy;
    int         loops;
    int         glitch;
    int         exp_en;
    logic [7:0] exp_last_add;
    int         exp_done_cyc;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One full sequence; expected stream is derived from the memory contents.
  task automatic run(input logic [7:0] b, input int n, input int rdy, input int loops,
                     input int glitch, output int n_en, output logic [7:0] last_add,
                     output int done_cyc);
    logic [7:0] addr_q[$];
    hs_t        hs_q[$];
    int cyc, first_v, done_cnt, budget, total, rw_bad, lim;
    logic [7:0] exp_a;
    addr_q.delete();
    hs_q.delete();
    @(negedge clk);
    base_add = b;
    num_pat  = 9'(n);
    start    = 1'b1;
`ifdef LBIST_SEQ_LOOP_EN
    loop_cnt = 8'(loops - 1);
`endif
    cyc = 0; first_v = -1; done_cnt = 0; done_cyc = -1; rw_bad = 0;
    budget = 50 * (n * loops + 2);
    while (cyc < budget) begin
      @(posedge clk);
      #1;
      cyc++;
      start = (cyc == glitch);
      if (cyc == glitch) begin
        base_add = ~b;
        num_pat  = 9'd5;
      end
      bus.pat_ready = ($urandom_range(99) < rdy);
      @(negedge clk);
      if (bus.mem_en) begin
        addr_q.push_back(bus.mem_add);
        if (bus.mem_rw !== MEM_READ) rw_bad++;
      end
      if (bus.pat_valid && first_v < 0) first_v = cyc;
      if (bus.pat_valid && bus.pat_ready) hs_q.push_back('{bus.pat_data, bus.pat_idx});
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (!busy) break;
    end
    bus.pat_ready = 1'b0;
    check("seq_terminated", busy, 1'b0);
    total = n * loops;
    check("mem_en_cycles", addr_q.size(), total);
    check("handshakes", hs_q.size(), total);
    lim = (addr_q.size() < total) ? addr_q.size() : total;
    for (int i = 0; i < lim; i++) begin
      exp_a = 8'((int'(b) + (i % n)) % 256);
      check("mem_add", addr_q[i], exp_a);
    end
    lim = (hs_q.size() < total) ? hs_q.size() : total;
    for (int i = 0; i < lim; i++) begin
      exp_a = 8'((int'(b) + (i % n)) % 256);
      check("pat_data", hs_q[i].d, mem[exp_a]);
      check("pat_idx", hs_q[i].idx, 9'(i % n));
    end
    check("done_pulses", done_cnt, 1);
    check("mem_rw_read", rw_bad, 0);
    if (rdy >= 100) check("first_valid_lat", first_v, (n > 0) ? 3 : -1);
    n_en     = addr_q.size();
    last_add = (addr_q.size() > 0) ? addr_q[addr_q.size()-1] : 8'h00;
    $display("run base=0x%02h num=%0d passes=%0d rdy=%0d%%: mem_en=%0d hs=%0d done@%0d",
             b, n, loops, rdy, addr_q.size(), hs_q.size(), done_cyc);
  endtask

  task automatic wait_valid(input string name);
    int k = 0;
    @(negedge clk);
    while (!bus.pat_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    check(name, bus.pat_valid, 1'b1);
  endtask

  task automatic pulse_start(input logic [7:0] b, input int n);
    @(negedge clk);
    base_add = b;
    num_pat  = 9'(n);
    start    = 1'b1;
`ifdef LBIST_SEQ_LOOP_EN
    loop_cnt = 8'd0;
`endif
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  vec_t vecs[$];

  initial begin
    int         n_en, done_cyc, bad, k, rn, rl;
    logic [7:0] last_add;
    bus.pat_ready = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mem_en", bus.mem_en, 1'b0);
    check("rst_pat_valid", bus.pat_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_pat_data", bus.pat_data, 8'h00);
    check("rst_pat_idx", bus.pat_idx, 9'h000);
    check("rst_mem_add", bus.mem_add, 8'h00);
    check("rst_mem_rw", bus.mem_rw, 1'b0);
    rst = 1'b0;
    $display("reset state checked");

    // base, num, ready%, passes, glitch-start cycle, mem_en cycles, last addr, done cycle
    vecs.push_back('{8'h00,   3, 100, 1, -1,   3, 8'h02,  10});
    vecs.push_back('{8'hFE,   4, 100, 1, -1,   4, 8'h01,  13});
    vecs.push_back('{8'h00,   0, 100, 1, -1,   0, 8'h00,   1});
    vecs.push_back('{8'h40,   2, 100, 1,  2,   2, 8'h41,   7});
    vecs.push_back('{8'h80,   5,  50, 1, -1,   5, 8'h84,  -1});
    vecs.push_back('{8'hFF, 256, 100, 1, -1, 256, 8'hFE, 769});
`ifdef LBIST_SEQ_LOOP_EN
    vecs.push_back('{8'h30,   2, 100, 3, -1,   6, 8'h31,  19});
`endif
    foreach (vecs[i]) begin
      run(vecs[i].base, vecs[i].num, vecs[i].rdy, vecs[i].loops, vecs[i].glitch,
          n_en, last_add, done_cyc);
      check("tbl_mem_en", n_en, vecs[i].exp_en);
      if (vecs[i].exp_en > 0) check("tbl_last_add", last_add, vecs[i].exp_last_add);
      if (vecs[i].exp_done_cyc >= 0) check("tbl_done_cyc", done_cyc, vecs[i].exp_done_cyc);
    end

    // Backpressure on pattern 1
    pulse_start(8'h00, 3);
    wait_valid("bp_valid0");
    check("bp_data0", bus.pat_data, 8'h11);
    bus.pat_ready = 1'b1;
    @(posedge clk);
    #1 bus.pat_ready = 1'b0;
    wait_valid("bp_valid1");
    check("bp_data1", bus.pat_data, 8'h22);
    check("bp_idx1", bus.pat_idx, 9'd1);
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (!bus.pat_valid || bus.pat_data !== 8'h22 || bus.pat_idx !== 9'd1 || bus.mem_en) bad++;
    end
    check("bp_stall_hold", bad, 0);
    bus.pat_ready = 1'b1;
    @(posedge clk);
    #1 bus.pat_ready = 1'b0;
    wait_valid("bp_valid2");
    check("bp_data2", bus.pat_data, 8'h33);
    check("bp_idx2", bus.pat_idx, 9'd2);
    bus.pat_ready = 1'b1;
    k = 0;
    @(negedge clk);
    while (!done && k < 10) begin
      @(negedge clk);
      k++;
    end
    check("bp_done", done, 1'b1);
    bus.pat_ready = 1'b0;
    @(negedge clk);
    $display("backpressure sequence complete");

    // Abort during PRESENT of pattern 1
    pulse_start(8'h00, 3);
    wait_valid("ab_valid0");
    bus.pat_ready = 1'b1;
    @(posedge clk);
    #1 bus.pat_ready = 1'b0;
    wait_valid("ab_valid1");
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    check("ab_busy", busy, 1'b0);
    check("ab_pat_valid", bus.pat_valid, 1'b0);
    bad = 0;
    repeat (4) begin
      if (done || bus.mem_en || busy) bad++;
      @(negedge clk);
    end
    check("ab_quiet", bad, 0);
    $display("abort sequence complete");

    // Start and abort together in IDLE
    @(negedge clk);
    base_add = 8'h00; num_pat = 9'd3; start = 1'b1; abort = 1'b1;
    @(posedge clk);
    #1 begin start = 1'b0; abort = 1'b0; end
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (busy || bus.mem_en || done) bad++;
    end
    check("start_abort_idle", bad, 0);
    $display("start+abort in idle complete");

    // Asynchronous reset in the middle of FETCH
    pulse_start(8'h10, 4);
    check("ar_in_fetch", bus.mem_en, 1'b1);
    #1 rst = 1'b1;
    #1;
    check("ar_mem_en", bus.mem_en, 1'b0);
    check("ar_pat_valid", bus.pat_valid, 1'b0);
    check("ar_busy", busy, 1'b0);
    @(negedge clk);
    check("ar_no_done", done, 1'b0);
    rst = 1'b0;
    run(8'h10, 4, 100, 1, -1, n_en, last_add, done_cyc);
    check("ar_rerun_done_cyc", done_cyc, 13);
    check("ar_rerun_last_add", last_add, 8'h13);

    // Random runs against the reference model
    for (int r = 0; r < 12; r++) begin
      rn = $urandom_range(1, 12);
`ifdef LBIST_SEQ_LOOP_EN
      rl = $urandom_range(1, 3);
`else
      rl = 1;
`endif
      run(8'($urandom), rn, $urandom_range(30, 100), rl, -1, n_en, last_add, done_cyc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
